mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares one memory/bus port among three requesters, such as instruction fetch, data access and a debug/DMA master. It accepts one transaction at a time. While a transaction is in progress it drives the 2-bit select of the port's 3:1 address/write-data multiplexers and runs the request/acknowledge handshake with the shared port. A watchdog aborts any transaction the port never acknowledges.

## Interface
- TIMEOUT, default 255: maximum number of BUSY cycles to wait for mem_ack_i, range 0..255; 0 disables the watchdog.

Clocking: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  3  request level per requester (bit n = requester n); must be held until ack_o[n] or err_o[n].
- we_i  in  3  write-enable per requester; only valid while the matching req_i bit is high.
- sel_o  out  2  select for the external 3:1 multiplexers: 2'b00 = requester 0, 2'b01 = requester 1, 2'b10 = requester 2; never 2'b11.
- gnt_o  out  3  one-hot owner indication; high from BUSY entry through DONE.
- mem_req_o  out  1  request to the shared port.
- mem_we_o  out  1  write-enable to the shared port; equals we_i[owner], registered at grant.
- mem_ack_i  in  1  one-cycle completion pulse from the shared port.
- ack_o  out  3  one-cycle pulse to the owner on successful completion.
- err_o  out  3  one-cycle pulse to the owner on watchdog abort.
- busy_o  out  1  high in BUSY and DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req_i bit is high, pick the winner by round-robin, starting at requester (last+1) mod 3.
  - Register the winner into sel_o, gnt_o and mem_we_o, update last, clear the watchdog counter, and go to BUSY.
  - If no req_i bit is high, stay in IDLE.
- BUSY:
  - mem_req_o = 1.
  - On mem_ack_i = 1, go to DONE in success mode.
  - Otherwise increment the 8-bit watchdog counter. When TIMEOUT != 0 and the counter reaches TIMEOUT, go to DONE in abort mode.
- DONE:
  - mem_req_o = 0.
  - Success mode: ack_o[owner] = 1. Abort mode: err_o[owner] = 1.
  - Always go to IDLE next.
  - gnt_o clears when leaving DONE.
- sel_o holds its last value in IDLE, so the multiplexer outputs stay stable; it changes only on the IDLE→BUSY transition.
- If mem_ack_i and the timeout occur in the same cycle, mem_ack_i wins (success).
- mem_ack_i outside BUSY is ignored.
- If req_i of the owner drops during BUSY, it is ignored and the transaction completes normally.
- New requests arriving during BUSY or DONE wait; they are not lost because req_i is level-held.
- Reset, from any state including mid-transaction:
  - state = IDLE.
  - last = 2, so requester 0 has first priority.
  - sel_o = 2'b00, gnt_o = 3'b000, mem_req_o = 0, mem_we_o = 0.
  - ack_o = err_o = 3'b000, busy_o = 0, watchdog counter = 0.
  - An in-flight port access is abandoned without ack_o or err_o.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Cycle sequence for one transaction:
  - Cycle 0: req_i is sampled high in IDLE.
  - Cycle 1: BUSY; mem_req_o, gnt_o and sel_o are valid.
  - If mem_ack_i = 1 in cycle k ≥ 1, then cycle k+1 is DONE and ack_o pulses.
  - Cycle k+2: IDLE.
- Minimum latency from req_i to ack_o is 2 cycles. Minimum spacing between transactions is 3 cycles.
- The requester must deassert req_i on the clock edge that ends its ack_o/err_o cycle. A req_i still high in the following IDLE cycle is treated as a new request.
- Abort timing: the counter counts cycles spent in BUSY without an acknowledge. err_o pulses in the cycle after the counter reaches TIMEOUT.

## Test plan
- Reset mid-BUSY (rst_i pulsed while mem_req_o = 1) → all outputs return to reset values immediately; no ack_o/err_o; the next req_i = 3'b010 is granted with sel_o = 2'b01.
- Single request: req_i = 3'b001, mem_ack_i on the first BUSY cycle → sel_o = 00 and mem_req_o = 1 in cycle 1; ack_o = 3'b001 in cycle 2; IDLE in cycle 3.
- Round robin: req_i = 3'b111 held, with each requester re-requesting after its ack → grant order 0, 1, 2, 0; sel_o sequence 00, 01, 10, 00.
- Fairness after reset: req_i = 3'b110 → requester 1 is granted first; then requester 2 after 1 drops.
- Watchdog: TIMEOUT = 4, no mem_ack_i → err_o[owner] pulses 5 cycles after BUSY entry. TIMEOUT = 0 → waits indefinitely.
- Ack/timeout collision: mem_ack_i in the cycle the counter hits TIMEOUT → ack_o pulses and err_o stays 0. A stray mem_ack_i in IDLE → no output change.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester/shared-port bundle for mem_port_arbiter
interface mem_port_arbiter_if;
   logic [2:0] req_i;
   logic [2:0] we_i;
   logic [1:0] sel_o;
   logic [2:0] gnt_o;
   logic       mem_req_o;
   logic       mem_we_o;
   logic       mem_ack_i;
   logic [2:0] ack_o;
   logic [2:0] err_o;
   logic       busy_o;

   modport slave (
      input  req_i, we_i, mem_ack_i,
      output sel_o, gnt_o, mem_req_o, mem_we_o, ack_o, err_o, busy_o
   );

   modport master (
      output req_i, we_i, mem_ack_i,
      input  sel_o, gnt_o, mem_req_o, mem_we_o, ack_o, err_o, busy_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - 3-way round-robin arbiter for one shared memory port
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic               clk_i,
   input logic               rst_i,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state_q;
   logic [1:0] last_q;
   logic [1:0] sel_q;
   logic [2:0] gnt_q;
   logic [2:0] ack_q;
   logic [2:0] err_q;
   logic       mem_req_q;
   logic       mem_we_q;
   logic       busy_q;
   logic [7:0] wd_q;
   logic [1:0] win_d;

   // Search order starts one past the previous owner.
   always_comb begin
      win_d = 2'd0;
      case (last_q)
         2'd0:    win_d = bus.req_i[1] ? 2'd1 : (bus.req_i[2] ? 2'd2 : 2'd0);
         2'd1:    win_d = bus.req_i[2] ? 2'd2 : (bus.req_i[0] ? 2'd0 : 2'd1);
         default: win_d = bus.req_i[0] ? 2'd0 : (bus.req_i[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         last_q    <= 2'd2;
         sel_q     <= 2'b00;
         gnt_q     <= 3'b000;
         ack_q     <= 3'b000;
         err_q     <= 3'b000;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         busy_q    <= 1'b0;
         wd_q      <= 8'd0;
      end else begin
         ack_q <= 3'b000;
         err_q <= 3'b000;
         case (state_q)
            IDLE: begin
               if (|bus.req_i) begin
                  sel_q     <= win_d;
                  gnt_q     <= 3'(3'b001 << win_d);
                  mem_we_q  <= bus.we_i[win_d];
                  last_q    <= win_d;
                  wd_q      <= 8'd0;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               // An acknowledge in the timeout cycle still counts as success.
               if (bus.mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  ack_q     <= gnt_q;
                  state_q   <= DONE;
               end else if ((TMO != 8'd0) && (wd_q == TMO)) begin
                  mem_req_q <= 1'b0;
                  err_q     <= gnt_q;
                  state_q   <= DONE;
               end else begin
                  wd_q <= wd_q + 8'd1;
               end
            end
            DONE: begin
               gnt_q   <= 3'b000;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.sel_o     = sel_q;
   assign bus.gnt_o     = gnt_q;
   assign bus.mem_req_o = mem_req_q;
   assign bus.mem_we_o  = mem_we_q;
   assign bus.ack_o     = ack_q;
   assign bus.err_o     = err_q;
   assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if a_if ();
   mem_port_arbiter_if z_if ();

   mem_port_arbiter #(.TIMEOUT(4)) dut  (.clk_i(clk), .rst_i(rst), .bus(a_if.slave));
   mem_port_arbiter #(.TIMEOUT(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(z_if.slave));

   int total = 0;
   int bad   = 0;
   logic [2:0] pend;
   int last_m;
   int w;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [2:0] r, input int last);
      for (int k = 1; k <= 3; k++)
         if (r[(last + k) % 3]) return (last + k) % 3;
      return 0;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      a_if.req_i = 3'b000; a_if.we_i = 3'b000; a_if.mem_ack_i = 1'b0;
      z_if.req_i = 3'b000; z_if.we_i = 3'b000; z_if.mem_ack_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      pend = 3'b000;
      last_m = 2;
   endtask

   // One transaction: ack arrives in BUSY cycle j_ack (1-based); outside 1..5 the watchdog fires.
   task automatic run_txn(input logic [2:0] add, input int j_ack, output int wo);
      logic [2:0] we;
      logic [2:0] oh;
      logic ok;
      int done_cyc;
      pend |= add;
      if (pend == 3'b000) pend = 3'(1 << $urandom_range(0, 2));
      we = 3'($urandom);
      a_if.req_i = pend;
      a_if.we_i  = we;
      wo = pick(pend, last_m);
      oh = 3'(1 << wo);
      ok = (j_ack >= 1) && (j_ack <= 5);
      done_cyc = ok ? j_ack + 1 : 6;
      step();
      chk("grant", {25'd0, a_if.busy_o, a_if.mem_req_o, a_if.gnt_o, a_if.sel_o},
                   {25'd0, 1'b1, 1'b1, oh, 2'(wo)});
      chk("mem_we", {31'd0, a_if.mem_we_o}, {31'd0, we[wo]});
      for (int j = 1; j < done_cyc; j++) begin
         a_if.mem_ack_i = (j == j_ack);
         step();
         a_if.mem_ack_i = 1'b0;
         if (j + 1 < done_cyc)
            chk("busy_wait", {25'd0, a_if.mem_req_o, a_if.ack_o, a_if.err_o}, {25'd0, 1'b1, 6'd0});
      end
      chk("ack", {29'd0, a_if.ack_o}, {29'd0, ok ? oh : 3'b000});
      chk("err", {29'd0, a_if.err_o}, {29'd0, ok ? 3'b000 : oh});
      chk("done", {27'd0, a_if.busy_o, a_if.mem_req_o, a_if.gnt_o}, {27'd0, 1'b1, 1'b0, oh});
      pend[wo] = 1'b0;
      a_if.req_i = pend;
      a_if.mem_ack_i = 1'($urandom);
      step();
      a_if.mem_ack_i = 1'b0;
      last_m = wo;
      chk("idle", {18'd0, a_if.busy_o, a_if.mem_req_o, a_if.gnt_o, a_if.ack_o, a_if.err_o, a_if.sel_o},
                  {18'd0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 2'(wo)});
   endtask

   initial begin
      logic [1:0] rr_exp [4];
      rr_exp[0] = 2'b00; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10; rr_exp[3] = 2'b00;

      do_reset();
      chk("reset_a", {19'd0, a_if.sel_o, a_if.gnt_o, a_if.mem_req_o, a_if.mem_we_o, a_if.ack_o, a_if.err_o, a_if.busy_o},
                     32'd0);
      chk("reset_z", {19'd0, z_if.sel_o, z_if.gnt_o, z_if.mem_req_o, z_if.mem_we_o, z_if.ack_o, z_if.err_o, z_if.busy_o},
                     32'd0);

      // Reset in the middle of a transaction
      a_if.req_i = 3'b001;
      a_if.we_i  = 3'b001;
      step();
      chk("pre_rst_busy", {31'd0, a_if.mem_req_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async", {19'd0, a_if.sel_o, a_if.gnt_o, a_if.mem_req_o, a_if.mem_we_o, a_if.ack_o, a_if.err_o, a_if.busy_o},
                       32'd0);
      a_if.req_i = 3'b000;
      step();
      rst = 1'b0;
      pend = 3'b000;
      last_m = 2;
      step();
      chk("rst_no_pulse", {26'd0, a_if.ack_o, a_if.err_o}, 32'd0);
      run_txn(3'b010, 1, w);
      chk("sel_after_rst", {30'd0, a_if.sel_o}, 32'd1);

      // Single request, fastest acknowledge
      do_reset();
      run_txn(3'b001, 1, w);
      chk("single_sel", {30'd0, a_if.sel_o}, 32'd0);

      // Round robin with all requesters re-requesting
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_txn(3'b111, 1 + i, w);
         chk("rr_sel", {30'd0, a_if.sel_o}, {30'd0, rr_exp[i]});
      end

      // Fairness after reset
      do_reset();
      run_txn(3'b110, 2, w);
      chk("fair_first", {30'd0, a_if.sel_o}, 32'd1);
      run_txn(3'b000, 3, w);
      chk("fair_second", {30'd0, a_if.sel_o}, 32'd2);

      // Watchdog abort and ack/timeout collision
      run_txn(3'b001, 0, w);
      run_txn(3'b100, 5, w);
      run_txn(3'b010, 6, w);

      // Stray acknowledge while idle
      a_if.req_i = 3'b000;
      pend = 3'b000;
      a_if.mem_ack_i = 1'b1;
      step();
      a_if.mem_ack_i = 1'b0;
      chk("stray_ack", {22'd0, a_if.busy_o, a_if.mem_req_o, a_if.gnt_o, a_if.ack_o, a_if.err_o}, 32'd0);
      step();
      chk("stray_ack2", {22'd0, a_if.busy_o, a_if.mem_req_o, a_if.gnt_o, a_if.ack_o, a_if.err_o}, 32'd0);

      // Watchdog disabled: waits past a full counter wrap
      z_if.req_i = 3'b100;
      z_if.we_i  = 3'b100;
      step();
      chk("z_grant", {25'd0, z_if.busy_o, z_if.mem_req_o, z_if.gnt_o, z_if.sel_o}, {25'd0, 2'b11, 3'b100, 2'b10});
      chk("z_we", {31'd0, z_if.mem_we_o}, 32'd1);
      for (int i = 0; i < 300; i++) begin
         step();
         if (z_if.err_o != 3'b000 || z_if.mem_req_o != 1'b1)
            chk("z_no_timeout", {28'd0, z_if.mem_req_o, z_if.err_o}, {28'd0, 1'b1, 3'b000});
      end
      chk("z_still_busy", {27'd0, z_if.busy_o, z_if.mem_req_o, z_if.err_o}, {27'd0, 2'b11, 3'b000});
      z_if.mem_ack_i = 1'b1;
      step();
      z_if.mem_ack_i = 1'b0;
      chk("z_ack", {26'd0, z_if.ack_o, z_if.err_o}, {26'd0, 3'b100, 3'b000});
      z_if.req_i = 3'b000;
      step();
      chk("z_idle", {28'd0, z_if.busy_o, z_if.gnt_o}, 32'd0);

      // Randomized traffic against the transaction-level model
      do_reset();
      for (int i = 0; i < 80; i++)
         run_txn(3'($urandom), int'($urandom_range(0, 7)), w);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
